reset_sequencer: RTL and testbench

Parametrised successor to the single-domain ESC-key reset generator. It produces NUM_DOMAINS active-high synchronous reset outputs that release in a staggered order, so the UART, vbuf and lab DUT can leave reset one after another. Two trigger sources restart the sequence: a configurable UART key byte and an external request. The block sits beside the UART at top level and drives every downstream reset.

---
 rtl/reset_sequencer.sv | 170 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Generates NUM_DOMAINS active-high reset outputs that release one after
// another: all bits are held for HOLD_CYCLES after a trigger, then bit 0
// releases, followed by each higher bit STAGGER cycles later. A trigger is
// either the UART key byte KEY or the level-sensitive ext_req input. Any
// trigger, in any phase, reasserts every output and restarts the sequence.
//
// Optional feature macro: RSTSEQ_DOUBLE_KEY_EN
//   When defined, the UART trigger needs two KEY bytes no more than KEY_WINDOW
//   cycles apart. When undefined, a single KEY byte triggers and no arming
//   logic exists.
//
// Ports:
//   clk          system clock
//   rst          block reset, synchronous, active-high
//   rx_data_rdy  UART byte valid strobe (1 cycle)
//   rx_data      UART byte
//   ext_req      external reset request, level-sensitive
//   rst_out      per-domain reset, active-high, registered; bit 0 releases first
//   seq_busy     high while any rst_out bit is high
//   seq_done     1-cycle strobe when the last domain releases
//   event_cnt    triggers seen since rst, saturating at 255
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int         NUM_DOMAINS = 3,
  parameter int         HOLD_CYCLES = 16,
  parameter int         STAGGER     = 4,
  parameter logic [7:0] KEY         = 8'h1b,
  parameter int         KEY_WINDOW  = 1200000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_data_rdy,
  input  logic [7:0]             rx_data,
  input  logic                   ext_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic [7:0]             event_cnt
);

  // Elaboration-time parameter sanity checks.
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_domains
    $error("reset_sequencer: NUM_DOMAINS must be 1..8");
  end
  if (HOLD_CYCLES < 1 || STAGGER < 1) begin : g_bad_timing
    $error("reset_sequencer: HOLD_CYCLES and STAGGER must be >= 1");
  end
  if (KEY_WINDOW < 1) begin : g_bad_window
    $error("reset_sequencer: KEY_WINDOW must be >= 1");
  end

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
  localparam logic [2:0]       LAST_IDX     = 3'(NUM_DOMAINS - 1);

  localparam logic [1:0] ASSERT  = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;

  logic key_byte;
  logic key_trigger;
  logic trigger;

  assign key_byte = rx_data_rdy && (rx_data == KEY);
  assign trigger  = key_trigger || ext_req;

`ifdef RSTSEQ_DOUBLE_KEY_EN
  localparam int               WIN_W    = $clog2(KEY_WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(KEY_WINDOW - 1);

  logic             armed;
  logic [WIN_W-1:0] win_cnt;

  // A KEY byte fires only when the previous KEY armed us within the window.
  assign key_trigger = key_byte && armed;

  always_ff @(posedge clk) begin
    if (rst || trigger) begin
      armed   <= 1'b0;
      win_cnt <= '0;
    end else if (rx_data_rdy) begin
      // KEY here means we were not armed (armed+KEY is a trigger above), so
      // it arms; any other byte disarms.
      armed   <= key_byte;
      win_cnt <= '0;
    end else if (armed) begin
      // win_cnt == KEY_WINDOW-1 marks the last cycle a second KEY may arrive.
      if (win_cnt == WIN_LAST) begin
        armed <= 1'b0;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
      end
    end
  end
`else
  assign key_trigger = key_byte;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop in this
  // block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ASSERT;
      cnt       <= '0;
      idx       <= '0;
      rst_out   <= '1;
      seq_busy  <= 1'b1;
      seq_done  <= 1'b0;
      event_cnt <= 8'd0;
    end else if (trigger) begin
      state    <= ASSERT;
      cnt      <= '0;
      idx      <= '0;
      rst_out  <= '1;
      seq_busy <= 1'b1;
      seq_done <= 1'b0;
      if (event_cnt != 8'hff) begin
        event_cnt <= event_cnt + 8'd1;
      end
    end else begin
      seq_done <= 1'b0;
      case (state)
        ASSERT: begin
          if (cnt == HOLD_LAST) begin
            // Shifting in zeros from the bottom releases bits strictly in
            // index order; a higher bit can never drop before a lower one.
            rst_out <= rst_out << 1;
            cnt     <= '0;
            idx     <= 3'd1;
            if (NUM_DOMAINS == 1) begin
              state    <= RUN;
              seq_done <= 1'b1;
              seq_busy <= 1'b0;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt == STAGGER_LAST) begin
            rst_out <= rst_out << 1;
            cnt     <= '0;
            idx     <= idx + 3'd1;
            if (idx == LAST_IDX) begin
              state    <= RUN;
              seq_done <= 1'b1;
              seq_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ; // RUN: outputs hold until the next trigger
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Scoreboard bench for reset_sequencer. Each cycle the driver applies inputs
// on the falling edge, advances a timing-based reference model (outputs are
// derived from the number of edges since the latest reset/trigger) and queues
// the expected post-edge outputs. A monitor pops one entry after every rising
// edge and compares it with the DUT. Compiles with or without
// RSTSEQ_DOUBLE_KEY_EN; the model follows the same macro.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int         N    = 3;
  localparam int         HOLD = 16;
  localparam int         STAG = 4;
  localparam int         WIN  = 100;
  localparam logic [7:0] KEY  = 8'h1b;

  typedef struct packed {
    logic [N-1:0] rst_out;
    logic         busy;
    logic         done;
    logic [7:0]   ev;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_data_rdy = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         ext_req = 1'b0;
  logic [N-1:0] rst_out;
  logic         seq_busy;
  logic         seq_done;
  logic [7:0]   event_cnt;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_DOMAINS(N),
    .HOLD_CYCLES(HOLD),
    .STAGGER    (STAG),
    .KEY        (KEY),
    .KEY_WINDOW (WIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data_rdy(rx_data_rdy),
    .rx_data    (rx_data),
    .ext_req    (ext_req),
    .rst_out    (rst_out),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done),
    .event_cnt  (event_cnt)
  );

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: edge numbers, not FSM states.
  int edge_n   = 0;
  int e0       = 0;
  int ev_m     = 0;
  bit armed_m  = 1'b0;
  int arm_edge = 0;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rst_out=%b busy=%b done=%b event_cnt=%0d, expected rst_out=%b busy=%b done=%b event_cnt=%0d",
               name, act.rst_out, act.busy, act.done, act.ev,
               exp.rst_out, exp.busy, exp.done, exp.ev);
    end
  endtask

  // Advance the model by one edge with the given inputs and queue the result.
  task automatic model(input bit r, input bit rdy, input logic [7:0] d, input bit ext);
    bit   key_trig;
    int   k;
    obs_t e;
    edge_n++;
    key_trig = 1'b0;
    if (r) begin
      e0      = edge_n;
      ev_m    = 0;
      armed_m = 1'b0;
    end else begin
`ifdef RSTSEQ_DOUBLE_KEY_EN
      if (rdy) begin
        if (d == KEY) begin
          if (armed_m && (edge_n - arm_edge) <= WIN) begin
            key_trig = 1'b1;
            armed_m  = 1'b0;
          end else begin
            armed_m  = 1'b1;
            arm_edge = edge_n;
          end
        end else begin
          armed_m = 1'b0;
        end
      end
`else
      key_trig = rdy && (d == KEY);
`endif
      if (key_trig || ext) begin
        e0      = edge_n;
        ev_m    = (ev_m < 255) ? ev_m + 1 : 255;
        armed_m = 1'b0;
      end
    end
    k = edge_n - e0;
    for (int i = 0; i < N; i++) begin
      e.rst_out[i] = (k < HOLD + i * STAG);
    end
    e.busy = (k < HOLD + (N - 1) * STAG);
    e.done = (k == HOLD + (N - 1) * STAG);
    e.ev   = ev_m[7:0];
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit rdy, input logic [7:0] d, input bit ext);
    @(negedge clk);
    rst         = r;
    rx_data_rdy = rdy;
    rx_data     = d;
    ext_req     = ext;
    model(r, rdy, d, ext);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(1'b0, 1'b0, 8'($urandom), 1'b0);
    end
  endtask

  task automatic key(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  // Monitor: one expected entry per rising edge, compared 1 time unit later.
  always @(posedge clk) begin
    obs_t act;
    obs_t e;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {rst_out, seq_busy, seq_done, event_cnt};
      check($sformatf("edge_%0d", edge_n), act, e);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion before 1000000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         r_rnd;
    bit         ext_rnd;
    bit         rdy_rnd;
    logic [7:0] d_rnd;

    // Power-on: rst for 3 cycles, then the full staggered release.
    repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);
    idle(30);

    // Single KEY in RUN retriggers; a non-KEY byte does nothing.
    key(KEY);
    idle(30);
    key(8'h41);
    idle(5);
    // KEY value without the valid strobe is ignored.
    step(1'b0, 1'b0, KEY, 1'b0);
    idle(3);

    // Retrigger during RELEASE (bit 0 already released).
    key(KEY);
    idle(17);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(30);

    // rst and ext_req on the same edge: rst wins.
    step(1'b1, 1'b0, 8'h00, 1'b1);
    idle(30);

    // ext_req held long enough to saturate event_cnt.
    repeat (300) step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(30);

    // Retrigger during ASSERT extends the hold.
    key(KEY);
    idle(7);
    key(KEY);
    idle(30);

    // Key-pair timing cases (single-key build retriggers on every KEY).
    step(1'b1, 1'b0, 8'h00, 1'b0);
    idle(30);
    key(KEY);
    idle(49);
    key(KEY);
    idle(30);
    key(KEY);
    key(8'h41);
    key(KEY);
    idle(30);
    key(KEY);
    idle(100);
    key(KEY);
    idle(9);
    key(KEY);
    idle(30);
    key(KEY);
    idle(99);
    key(KEY);
    idle(30);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r_rnd   = ($urandom_range(0, 499) == 0);
      ext_rnd = ($urandom_range(0, 149) == 0);
      rdy_rnd = ($urandom_range(0, 9) == 0);
      d_rnd   = ($urandom_range(0, 2) == 0) ? KEY : 8'($urandom);
      step(r_rnd, rdy_rnd, d_rnd, ext_rnd);
    end
    idle(30);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
